mul_seq: RTL and testbench

Iterative 32×32 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. It sits in the execute stage beside the ALU. It accepts operands through a valid/ready handshake and produces one 32-bit result after a fixed 34-cycle latency. Every partial-product accumulation goes through the team's 32-bit CLA adder, which is built from 4-bit CLA slices.

---
 rtl/mul_pkg.sv | 23 ++
 rtl/adder_32_cla.sv | 36 +++
 rtl/mul_seq.sv | 120 ++++++++++++
 tb/tb_mul_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative RV32M multiplier: widths, op encodings and FSM states.
package mul_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  // Index of the final shift-add step in CALC.
  localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

  // funct3[1:0] of the RV32M multiply group
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/adder_32_cla.sv
// 32-bit adder built from eight 4-bit carry-lookahead slices, carry rippling between slices.
module adder_32_cla (
  input  logic        c0,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        cout
);

  logic [8:0] slice_c;

  assign slice_c[0] = c0;

  for (genvar i = 0; i < 8; i++) begin : g_slice
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a[4*i +: 4] & b[4*i +: 4];
    assign p = a[4*i +: 4] ^ b[4*i +: 4];

    // All slice carries are resolved from the slice carry-in in parallel.
    assign c[0] = slice_c[i];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s[4*i +: 4]  = p ^ c[3:0];
    assign slice_c[i+1] = c[4];
  end

  assign cout = slice_c[8];

endmodule

// File: rtl/mul_seq.sv
// Iterative 32x32 shift-add multiplier for MUL/MULH/MULHSU/MULHU with a fixed 34-cycle latency.
// Operands are reduced to magnitudes, multiplied unsigned, and the sign is applied once at the end.
module mul_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  import mul_pkg::*;

  state_e              state_q, state_d;
  logic [2*XLEN-1:0]   p_q, p_d;
  logic [XLEN-1:0]     m_q, m_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic                neg_q, neg_d;

  logic                sa, sb;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN-1:0]     add_b;
  logic [XLEN-1:0]     add_s;
  logic                add_c;

  // MUL takes the unsigned path: its low word does not depend on operand signedness.
  assign sa = a[XLEN-1] & ((op == MUL_OP_MULH) | (op == MUL_OP_MULHSU));
  assign sb = b[XLEN-1] & (op == MUL_OP_MULH);

  // 0x80000000 negates to itself, which is the correct magnitude when read unsigned.
  assign a_mag = sa ? (~a + XLEN'(1)) : a;
  assign b_mag = sb ? (~b + XLEN'(1)) : b;

  assign add_b = p_q[0] ? m_q : '0;

  adder_32_cla u_adder (
    .c0   (1'b0),
    .a    (p_q[2*XLEN-1:XLEN]),
    .b    (add_b),
    .s    (add_s),
    .cout (add_c)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StCalc;
          op_d    = op;
          neg_d   = sa ^ sb;
          p_d     = {{XLEN{1'b0}}, b_mag};
          m_d     = a_mag;
          cnt_d   = '0;
        end
      end
      StCalc: begin
        // Keeping the adder carry in the shift makes P the exact 64-bit magnitude product.
        p_d   = {add_c, add_s, p_q[XLEN-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (neg_q) begin
          p_d = ~p_q + (2*XLEN)'(1);
        end
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          p_d     = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      p_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = (op_q == MUL_OP_MUL) ? p_q[XLEN-1:0] : p_q[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases plus randomized ops against a
// 64-bit arithmetic reference product.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mul_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Sign/zero-extend per op and multiply; the low 64 bits of the true product are exact.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    logic [63:0] ex, ey, pr;
    ex = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'h0, x};
    ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'h0, y};
    pr = ex * ey;
    return (o == 2'b00) ? pr[31:0] : pr[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, check latency and result, hold off the consumer for `stall` cycles,
  // then take the result. With `noise`, in_valid is toggled with junk while busy.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int stall,
                        input bit noise);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      a  = $urandom;
      b  = $urandom;
      op = 2'($urandom);
      if (noise) in_valid = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check_eq({tag, "_latency"}, 32'(lat), 32'd34);
    check_eq({tag, "_result"}, result, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_hold_result"}, result, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_post_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_post_result"}, result, 32'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_result", result, 32'd0);

    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000_002A, 0, 1'b0);
    run_op("mulh_m1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0);
    run_op("mulhu_m1", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0);
    run_op("mulhsu_m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 1'b0);
    run_op("mul_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 0, 1'b0);
    run_op("mulhu_bp", 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 10, 1'b1);

    // Reset in the middle of CALC discards the op.
    op       = 2'b00;
    a        = 32'd100;
    b        = 32'd200;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_result", result, 32'd0);
    run_op("mul_3x5", 2'b00, 32'd3, 32'd5, 32'h0000_000F, 0, 1'b0);

    // Reset while a result is pending in DONE.
    op       = 2'b11;
    a        = 32'hFFFF_FFFF;
    b        = 32'h0000_0002;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("done_pending", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("donerst_out_valid", 32'(out_valid), 32'd0);
    check_eq("donerst_result", result, 32'd0);

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ro = 2'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      run_op("rand", ro, ra, rb, ref_mul(ro, ra, rb), $urandom_range(0, 3), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
